ht_ltf_streamer: RTL and testbench



---
 rtl/ht_ltf_streamer_pkg.sv | 31 +++
 rtl/ht_ltf_streamer_if.sv | 13 +
 rtl/iq_skid_buf.sv | 60 ++++++
 rtl/ht_ltf_streamer.sv | 167 ++++++++++++++++
 tb/tb_ht_ltf_streamer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ht_ltf_streamer_pkg.sv
// Shared constants, state encoding and payload type for the HT-LTF streamer.
// Optional windowing sample is enabled by defining HT_LTF_WIN_EN.
package ht_ltf_streamer_pkg;

  localparam int unsigned HT_CP_LEN   = 16;
  localparam int unsigned HT_SYM_LEN  = 64;
  localparam int unsigned HT_ROM_AW   = 7;
  localparam int unsigned HT_IQ_W     = 32;
  localparam int unsigned HT_CP_START = HT_SYM_LEN - HT_CP_LEN;
  localparam int unsigned HT_WIN_ADDR = HT_SYM_LEN;

  // P-matrix row for spatial stream 0; a set bit negates that symbol.
  localparam logic [3:0] HT_P_SIGN = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic               last;
    logic [HT_IQ_W-1:0] data;
  } iq_word_t;

  // Two's-complement negate that maps -32768 to +32767.
  function automatic logic [15:0] neg_sat16(input logic [15:0] x);
    return (x == 16'h8000) ? 16'h7fff : 16'(~x + 16'd1);
  endfunction

endpackage

// File: rtl/ht_ltf_streamer_if.sv
// Valid/ready sample stream from the HT-LTF streamer towards the sample mux.
interface ht_ltf_streamer_if;
  import ht_ltf_streamer_pkg::*;

  logic [HT_IQ_W-1:0] o_data;
  logic               o_valid;
  logic               o_ready;
  logic               o_last;

  modport master (output o_data, output o_valid, output o_last, input o_ready);
  modport slave  (input o_data, input o_valid, input o_last, output o_ready);

endinterface

// File: rtl/iq_skid_buf.sv
// Two-entry valid/ready skid buffer; upstream ready depends only on local state.
module iq_skid_buf
  import ht_ltf_streamer_pkg::*;
(
  input  logic     clk,
  input  logic     rstn,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  iq_word_t in_word_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output iq_word_t out_word_o
);

  iq_word_t out_q, out_d, skid_q, skid_d;
  logic     out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic     push_c, pop_c;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // The output slot refills from the skid slot first so ordering is preserved.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    push_c       = in_valid_i && !skid_valid_q;
    pop_c        = out_valid_q && out_ready_i;
    if (!out_valid_q || pop_c) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push_c;
        if (push_c) out_d = in_word_i;
      end
    end else if (push_c) begin
      skid_d       = in_word_i;
      skid_valid_d = 1'b1;
    end
  end

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_word_o  = out_q;

endmodule

// File: rtl/ht_ltf_streamer.sv
// Streams 1/2/4 HT-LTF symbols (CP + body) from the sample ROM with P-matrix signs.
// Define HT_LTF_WIN_EN to append one windowing sample from ROM address 64.
module ht_ltf_streamer
  import ht_ltf_streamer_pkg::*;
#(
  parameter int unsigned CP_LEN  = HT_CP_LEN,
  parameter int unsigned SYM_LEN = HT_SYM_LEN
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [2:0]           num_ltf,
  output logic [HT_ROM_AW-1:0] rom_addr,
  input  logic [HT_IQ_W-1:0]   rom_dout,
  ht_ltf_streamer_if.master    strm,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [6:0] LAST_SMP = 7'(CP_LEN + SYM_LEN - 1);

  state_e     state_q, state_d;
  logic [6:0] samp_q, samp_d;
  logic [1:0] sym_q, sym_d;
  logic [2:0] nsym_q, nsym_d;
  logic [6:0] addr_q, addr_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic       win_q, win_d;

  logic       in_valid_c, in_ready_c, last_sym_c, legal_c, last_xfer_c;
  iq_word_t   in_word_c, out_word;
  logic       out_valid;

  // Sample index within a symbol to ROM address: CP tail first, then the body.
  function automatic logic [6:0] smp_addr(input logic [6:0] idx);
    return (idx < 7'(CP_LEN)) ? 7'(HT_CP_START) + idx : idx - 7'(CP_LEN);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      samp_q  <= '0;
      sym_q   <= '0;
      nsym_q  <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      sym_q   <= sym_d;
      nsym_q  <= nsym_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      win_q   <= win_d;
    end
  end

  assign legal_c     = (num_ltf == 3'd1) || (num_ltf == 3'd2) || (num_ltf == 3'd4);
  assign last_sym_c  = ({1'b0, sym_q} == (nsym_q - 3'd1));
  assign last_xfer_c = out_valid && strm.o_ready && out_word.last;

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    sym_d      = sym_q;
    nsym_d     = nsym_q;
    addr_d     = addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    win_d      = win_q;
    in_valid_c = 1'b0;

    in_word_c.data = HT_P_SIGN[sym_q] ?
                     {neg_sat16(rom_dout[31:16]), neg_sat16(rom_dout[15:0])} : rom_dout;
`ifdef HT_LTF_WIN_EN
    in_word_c.last = win_q;
`else
    in_word_c.last = (samp_q == LAST_SMP) && last_sym_c;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (legal_c) begin
            nsym_d  = num_ltf;
            samp_d  = '0;
            sym_d   = '0;
            win_d   = 1'b0;
            addr_d  = smp_addr(7'd0);
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        in_valid_c = 1'b1;
        if (in_ready_c) begin
`ifdef HT_LTF_WIN_EN
          if (win_q) begin
            win_d   = 1'b0;
            addr_d  = '0;
            state_d = ST_DRAIN;
          end else
`endif
          if (samp_q == LAST_SMP) begin
            samp_d = '0;
            if (last_sym_c) begin
`ifdef HT_LTF_WIN_EN
              win_d  = 1'b1;
              addr_d = 7'(HT_WIN_ADDR);
`else
              addr_d  = '0;
              state_d = ST_DRAIN;
`endif
            end else begin
              sym_d  = sym_q + 2'd1;
              addr_d = smp_addr(7'd0);
            end
          end else begin
            samp_d = samp_q + 7'd1;
            addr_d = smp_addr(samp_q + 7'd1);
          end
        end
      end

      ST_DRAIN: begin
        if (last_xfer_c) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  iq_skid_buf u_skid (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid_i  (in_valid_c),
    .in_ready_o  (in_ready_c),
    .in_word_i   (in_word_c),
    .out_valid_o (out_valid),
    .out_ready_i (strm.o_ready),
    .out_word_o  (out_word)
  );

  assign strm.o_data  = out_word.data;
  assign strm.o_last  = out_word.last;
  assign strm.o_valid = out_valid;
  assign rom_addr     = addr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ht_ltf_streamer.sv
// Scoreboard bench for ht_ltf_streamer; expected bursts are built from a local ROM image.
module tb_ht_ltf_streamer;
  import ht_ltf_streamer_pkg::*;

`ifdef HT_LTF_WIN_EN
  localparam int WIN = 1;
`else
  localparam int WIN = 0;
`endif
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  num_ltf = 3'd0;
  logic [6:0]  rom_addr;
  logic [31:0] rom_dout;
  logic        busy, done, err;

  logic [31:0] rom [0:79];
  iq_word_t    exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          bad_addr = 0;

  ht_ltf_streamer_if strm_if ();

  ht_ltf_streamer dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .num_ltf  (num_ltf),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .strm     (strm_if.master),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (int'(rom_addr) < 80) rom_dout = rom[int'(rom_addr)];
    else                     rom_dout = 32'h0;
  end

  always @(posedge clk) begin
    if (busy && (int'(rom_addr) > (WIN != 0 ? 64 : 63))) bad_addr++;
  end

  function automatic logic [15:0] neg16(input logic [15:0] x);
    int v;
    v = -int'($signed(x));
    if (v > 32767) v = 32767;
    return 16'(v);
  endfunction

  function automatic logic [31:0] sign_word(input logic [31:0] w, input int k);
    if (k == 1) return {neg16(w[31:16]), neg16(w[15:0])};
    return w;
  endfunction

  task automatic push_expected(input int n);
    iq_word_t e;
    int a;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      for (int s = 0; s < 80; s++) begin
        a = (s < 16) ? (HT_CP_START + s) : (s - 16);
        e.data = sign_word(rom[a], k);
        e.last = (WIN == 0) && (k == n - 1) && (s == 79);
        exp_q.push_back(e);
      end
    end
    if (WIN != 0) begin
      e.data = sign_word(rom[HT_WIN_ADDR], n - 1);
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Runs one burst; abort_after>0 asserts reset once that many samples were seen.
  task automatic run_burst(input int n, input bit rnd, input int abort_after);
    int cyc, xfers, first_cyc, last_cyc, done_cyc, nexp;
    bit stalled, err_seen, busy_gap, aborted;
    iq_word_t held, got, e;
    nexp = 80 * n + WIN;
    push_expected(n);
    cyc = 0; xfers = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1;
    stalled = 0; err_seen = 0; busy_gap = 0; aborted = 0;
    @(negedge clk);
    start = 1'b1; num_ltf = 3'(n);
    while (cyc < BUDGET && done_cyc < 0 && !aborted) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 40) begin start = 1'b1; num_ltf = 3'd3; end
      if (cyc == 41) begin start = 1'b1; num_ltf = 3'd2; end
      strm_if.o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      got.data = strm_if.o_data; got.last = strm_if.o_last;
      if (cyc == 1) begin
        checks++;
        if (rom_addr !== 7'd48 || busy !== 1'b1) begin
          errors++;
          $display("FAIL first_addr: rom_addr=%0d busy=%b, want 48/1", rom_addr, busy);
        end
      end
      if (err) err_seen = 1;
      if (done) begin
        done_cyc = cyc;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_fall: busy=%b at done, want 0", busy);
        end
      end else if (!busy) busy_gap = 1;
      if (stalled) begin
        checks++;
        if (strm_if.o_valid !== 1'b1 || got !== held) begin
          errors++;
          $display("FAIL stall_hold: valid=%b word=%h, want 1/%h", strm_if.o_valid, got, held);
        end
      end
      if (strm_if.o_valid && first_cyc < 0) first_cyc = cyc;
      stalled = 0;
      if (strm_if.o_valid && strm_if.o_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_sample: got %h, want no sample", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL sample[%0d]: got %h, want %h", xfers, got, e);
          end
        end
        if (xfers == 0) begin
          checks++;
          if (got.data !== rom[48]) begin
            errors++;
            $display("FAIL sample1: got %h, want %h", got.data, rom[48]);
          end
        end
        if (xfers == 16) begin
          checks++;
          if (got.data !== 32'h0800_0400) begin
            errors++;
            $display("FAIL sample17: got %h, want 08000400", got.data);
          end
        end
        if (n >= 2 && xfers == 96) begin
          checks++;
          if (got.data !== 32'hF800_FC00) begin
            errors++;
            $display("FAIL sample97: got %h, want f800fc00", got.data);
          end
        end
        if (n >= 2 && xfers == 82) begin
          checks++;
          if (got.data !== 32'h7FFF_7FFF) begin
            errors++;
            $display("FAIL neg_sat: got %h, want 7fff7fff", got.data);
          end
        end
        if (got.last) last_cyc = cyc;
        xfers++;
        if (abort_after > 0 && xfers == abort_after) aborted = 1;
      end else if (strm_if.o_valid) begin
        stalled = 1;
        held = got;
      end
    end

    if (aborted) begin
      rstn = 1'b0;
      #1;
      checks++;
      if ({strm_if.o_valid, strm_if.o_last, busy, done, err} !== 5'b0 ||
          strm_if.o_data !== 32'h0 || rom_addr !== 7'd0) begin
        errors++;
        $display("FAIL reset_mid: valid=%b last=%b busy=%b done=%b err=%b data=%h addr=%0d, want all 0",
                 strm_if.o_valid, strm_if.o_last, busy, done, err, strm_if.o_data, rom_addr);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      strm_if.o_ready = 1'b1;
      err_seen = 0;
      repeat (6) begin
        @(negedge clk);
        if (strm_if.o_valid || done || busy || err) err_seen = 1;
      end
      checks++;
      if (err_seen) begin
        errors++;
        $display("FAIL post_reset_quiet: activity after reset, want none");
      end
      return;
    end

    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, want done", BUDGET);
    end
    checks++;
    if (xfers != nexp || exp_q.size() != 0) begin
      errors++;
      $display("FAIL burst_len: got %0d transfers (%0d left), want %0d", xfers, exp_q.size(), nexp);
    end
    checks++;
    if (done_cyc != last_cyc + 1) begin
      errors++;
      $display("FAIL done_delay: done at %0d last at %0d, want last+1", done_cyc, last_cyc);
    end
    checks++;
    if (err_seen || busy_gap) begin
      errors++;
      $display("FAIL ignore_start: err=%b busy_gap=%b, want 0/0", err_seen, busy_gap);
    end
    if (!rnd) begin
      checks++;
      if (first_cyc != 2 || last_cyc != 1 + 80 * n + WIN) begin
        errors++;
        $display("FAIL timing: first=%0d last=%0d, want 2/%0d", first_cyc, last_cyc, 1 + 80 * n + WIN);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || strm_if.o_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b valid=%b after pulse, want 0/0", done, strm_if.o_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({strm_if.o_valid, strm_if.o_last, busy, done, err} !== 5'b0 ||
        strm_if.o_data !== 32'h0 || rom_addr !== 7'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b done=%b err=%b data=%h addr=%0d, want all 0",
               strm_if.o_valid, strm_if.o_last, busy, done, err, strm_if.o_data, rom_addr);
    end
    rstn = 1'b1;
  endtask

  task automatic test_illegal(input logic [2:0] n);
    bit act;
    @(negedge clk);
    start = 1'b1; num_ltf = n;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err: err=%b busy=%b for num_ltf=%0d, want 1/0", err, busy, n);
    end
    act = 0;
    repeat (5) begin
      @(negedge clk);
      if (err || busy || strm_if.o_valid) act = 1;
    end
    checks++;
    if (act) begin
      errors++;
      $display("FAIL illegal_quiet: activity after illegal start, want none");
    end
  endtask

  task automatic test_single();         run_burst(1, 1'b0, 0);  endtask
  task automatic test_two();            run_burst(2, 1'b0, 0);  endtask
  task automatic test_four_random();    run_burst(4, 1'b1, 0);  endtask
  task automatic test_reset_mid_burst(); run_burst(4, 1'b1, 100); run_burst(1, 1'b0, 0); endtask
  task automatic test_back_to_back();   run_burst(4, 1'b0, 0); run_burst(2, 1'b1, 0); endtask

  initial begin
    for (int i = 0; i < 80; i++)
      rom[i] = {16'(i * 97 + 3), 16'(16'hF000 - 16'(i * 33))};
    rom[0]  = 32'h0800_0400;
    rom[50] = 32'h8000_8000;
    rom[51] = 32'h8000_1234;
    rom[HT_WIN_ADDR] = rom[0];
    strm_if.o_ready = 1'b1;

    test_reset();
    test_single();
    test_two();
    test_four_random();
    test_illegal(3'd3);
    test_illegal(3'd0);
    test_reset_mid_burst();
    test_back_to_back();

    checks++;
    if (bad_addr != 0) begin
      errors++;
      $display("FAIL addr_range: %0d out-of-range addresses, want 0", bad_addr);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
